video_timing_stream: RTL

Parametrised successor to the fixed 800x600 video timing/data block in the camera-to-HDMI path. It generates programmable H/V timing and pulls pixels from an external single-clock FIFO read port with 1-cycle read latency. Pixel source is selectable per frame: live stream, colour bars or solid colour. It adds a frame-start request to the capture side and saturating underflow accounting. Outputs hs/vs/de/vout_data feed the DVI/TMDS transmitter directly.

---
 rtl/video_timing_pkg.sv | 51 +++++
 rtl/video_sync_counter.sv | 65 ++++++
 rtl/video_timing_stream.sv | 126 ++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared mode encodings, colour-bar palettes and timing-bound arithmetic for the video timing path.
// Pure definitions; no logic, latency or flow control here.
package video_timing_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_SOLID  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef struct packed {
    int unsigned h_total;
    int unsigned hs_start;
    int unsigned hs_end;
    int unsigned v_total;
    int unsigned vs_start;
    int unsigned vs_end;
  } timing_t;

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BAR_RGB565 [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };
  localparam logic [23:0] BAR_RGB888 [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic timing_t calc_timing(
    input int unsigned h_act, input int unsigned h_fp, input int unsigned h_sync,
    input int unsigned h_bp, input int unsigned v_act, input int unsigned v_fp,
    input int unsigned v_sync, input int unsigned v_bp
  );
    timing_t t;
    t.h_total  = h_act + h_fp + h_sync + h_bp;
    t.hs_start = h_act + h_fp;
    t.hs_end   = h_act + h_fp + h_sync;
    t.v_total  = v_act + v_fp + v_sync + v_bp;
    t.vs_start = v_act + v_fp;
    t.vs_end   = v_act + v_fp + v_sync;
    return t;
  endfunction

  function automatic logic [23:0] bar_color(input logic [2:0] idx, input int unsigned data_w);
    return (data_w == 24) ? BAR_RGB888[idx] : {8'h00, BAR_RGB565[idx]};
  endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Free-running h/v raster counters with combinational active/sync window decodes (stage 0).
// Decodes are same-cycle as the counters; no backpressure, the raster never stalls.
module video_sync_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             de_pre_o,
  output logic             hs_pre_o,
  output logic             vs_pre_o
);

  localparam timing_t T = calc_timing(H_ACTIVE, H_FP, H_SYNC, H_BP,
                                      V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(T.h_total - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(T.v_total - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(T.hs_start);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(T.hs_end);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(T.vs_start);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(T.vs_end);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign de_pre_o = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  // Vertical window keys off v_cnt alone, so vs only ever moves when h_cnt wraps to 0.
  assign hs_pre_o = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_pre_o = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

endmodule

// File: rtl/video_timing_stream.sv
// Programmable video timing with per-frame pixel source (FIFO stream, colour bars, solid colour).
// All outputs lag the raster counters by 1 clock; an empty FIFO never stalls timing, it emits black and is counted.
module video_timing_stream
  import video_timing_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] solid_color,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              frame_req,
  output logic [15:0]       underflow_cnt,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [DATA_W-1:0] vout_data
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic              de_pre, hs_pre, vs_pre;

  mode_e             mode_q, mode_eff;
  logic [DATA_W-1:0] solid_q, solid_eff;
  logic [DATA_W-1:0] pix_d, pix_q;
  logic [15:0]       uf_d, uf_q;
  logic              hs_d, vs_d;
  logic              rd_q, de_q, hs_q, vs_q, frame_req_q;
  logic              frame_start, vblank_start, stream_px;
  int unsigned       bar_div;
  logic [2:0]        bar_idx;

  video_sync_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_sync (
    .clk_i    (video_clk),
    .rst_i    (rst),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .de_pre_o (de_pre),
    .hs_pre_o (hs_pre),
    .vs_pre_o (vs_pre)
  );

  always_comb begin
    frame_start  = (h_cnt == '0) && (v_cnt == '0);
    vblank_start = (h_cnt == '0) && (v_cnt == CNT_W'(V_ACTIVE));
    // The first pixel of a frame already belongs to the newly sampled mode.
    mode_eff     = frame_start ? mode_e'(mode) : mode_q;
    solid_eff    = frame_start ? solid_color : solid_q;

    bar_div = 32'(h_cnt) / BAR_W;
    bar_idx = (bar_div > 32'd7) ? 3'd7 : bar_div[2:0];

    stream_px  = de_pre && (mode_eff == MODE_STREAM);
    fifo_rd_en = stream_px && !fifo_empty && !rst;

    uf_d = uf_q;
    if (stream_px && fifo_empty && (uf_q != 16'hFFFF)) begin
      uf_d = uf_q + 16'd1;
    end

    pix_d = '0;
    if (de_pre) begin
      case (mode_eff)
        MODE_BARS:  pix_d = DATA_W'(bar_color(bar_idx, DATA_W));
        MODE_SOLID: pix_d = solid_eff;
        default:    pix_d = '0;
      endcase
    end

    hs_d = hs_pre ? HS_POL : !HS_POL;
    vs_d = vs_pre ? VS_POL : !VS_POL;
  end

  always_ff @(posedge video_clk) begin
    if (rst) begin
      mode_q      <= MODE_STREAM;
      solid_q     <= '0;
      uf_q        <= '0;
      pix_q       <= '0;
      rd_q        <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= !HS_POL;
      vs_q        <= !VS_POL;
      frame_req_q <= 1'b0;
    end else begin
      if (frame_start) begin
        mode_q  <= mode_eff;
        solid_q <= solid_color;
      end
      uf_q        <= uf_d;
      pix_q       <= pix_d;
      rd_q        <= fifo_rd_en;
      de_q        <= de_pre;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      frame_req_q <= vblank_start;
    end
  end

  // The FIFO's 1-cycle read latency acts as the output register for streamed pixels.
  assign vout_data     = rd_q ? fifo_rd_data : pix_q;
  assign de            = de_q;
  assign hs            = hs_q;
  assign vs            = vs_q;
  assign frame_req     = frame_req_q;
  assign underflow_cnt = uf_q;

endmodule
